// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem reads,
// and a 2-entry instruction buffer toward decode with redirect/squash.
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t      state;
  logic        started;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [1:0]  count;
  logic [31:0] head_data, head_pc, head_pc4;
  logic [31:0] tail_data, tail_pc;

  logic       rsp_take;
  logic       push;
  logic       pop;
  logic       accept;
  logic [1:0] count_after;

  // A response only counts when something is actually outstanding.
  assign rsp_take    = imem_rsp_valid && (state != IDLE);
  assign push        = rsp_take && (state == WAIT) && !redirect;
  assign pop         = inst_valid && inst_ready && !redirect;
  assign count_after = count + {1'b0, push} - {1'b0, pop};

  // Every buffered entry plus the next in-flight request must fit in the buffer.
  assign imem_req_valid = started && !redirect && ((state == IDLE) || rsp_take)
                          && (count_after < DEPTH);
  assign accept         = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = pc;

  assign inst_valid = (count != 2'd0);
  assign inst_data  = head_data;
  assign inst_pc    = head_pc;
  assign inst_pc4   = head_pc4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      started   <= 1'b0;
      pc        <= RESET_PC;
      req_pc    <= 32'h0;
      count     <= 2'd0;
      head_data <= 32'h0;
      head_pc   <= 32'h0;
      head_pc4  <= 32'h4;
      tail_data <= 32'h0;
      tail_pc   <= 32'h0;
    end else begin
      started <= 1'b1;
      if (redirect) begin
        pc    <= {redirect_target[31:2], 2'b00};
        count <= 2'd0;
        state <= ((state != IDLE) && !imem_rsp_valid) ? WAIT_DROP : IDLE;
      end else begin
        count <= count_after;
        if (accept) begin
          pc     <= pc + 32'd4;
          req_pc <= pc;
          state  <= WAIT;
        end else if (rsp_take) begin
          state <= IDLE;
        end
        // Shift-register buffer: head always holds the oldest entry.
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              head_data <= imem_rsp_data;
              head_pc   <= req_pc;
              head_pc4  <= req_pc + 32'd4;
            end else begin
              tail_data <= imem_rsp_data;
              tail_pc   <= req_pc;
            end
          end
          2'b01: begin
            head_data <= tail_data;
            head_pc   <= tail_pc;
            head_pc4  <= tail_pc + 32'd4;
          end
          2'b11: begin
            if (count == 2'd1) begin
              head_data <= imem_rsp_data;
              head_pc   <= req_pc;
              head_pc4  <= req_pc + 32'd4;
            end else begin
              head_data <= tail_data;
              head_pc   <= tail_pc;
              head_pc4  <= tail_pc + 32'd4;
              tail_data <= imem_rsp_data;
              tail_pc   <= req_pc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction memory.
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect(redirect), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_pc4(inst_pc4)
  );

  always #5 clk = ~clk;

  // Memory: data = addr ^ KEY, returned mem_lat cycles after accept; not reset.
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  always @(posedge clk) begin
    imem_rsp_valid <= 1'b0;
    if (mem_cnt == 1) begin
      imem_rsp_valid <= 1'b1;
      imem_rsp_data  <= mem_addr ^ KEY;
    end
    if (mem_cnt > 0) mem_cnt <= mem_cnt - 1;
    if (imem_req_valid && imem_req_ready) begin
      if (mem_lat == 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= imem_req_addr ^ KEY;
      end else begin
        mem_cnt  <= mem_lat - 1;
        mem_addr <= imem_req_addr;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_inst(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (inst_valid) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  typedef struct {
    logic        ir;
    logic        rd;
    logic [31:0] tgt;
    logic        erv;
    logic [31:0] eaddr;
    logic        eiv;
    logic [31:0] epc;
  } vec_t;

  function automatic vec_t mk(logic ir, logic rd, logic [31:0] tgt, logic erv,
                              logic [31:0] eaddr, logic eiv, logic [31:0] epc);
    vec_t v;
    v.ir = ir; v.rd = rd; v.tgt = tgt; v.erv = erv;
    v.eaddr = eaddr; v.eiv = eiv; v.epc = epc;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    bit ok;
    bit seen;

    // Rows follow release of reset, 1-cycle memory.
    vecs[0]  = mk(1, 0, 0, 1, 32'h0,   0, 0);
    vecs[1]  = mk(1, 0, 0, 1, 32'h4,   0, 0);
    for (int i = 2; i < 8; i++) vecs[i] = mk(0, 0, 0, 0, 0, 1, 32'h0);
    vecs[8]  = mk(1, 0, 0, 1, 32'h8,   1, 32'h0);
    vecs[9]  = mk(1, 0, 0, 1, 32'hC,   1, 32'h4);
    vecs[10] = mk(1, 0, 0, 1, 32'h10,  1, 32'h8);
    vecs[11] = mk(1, 0, 0, 1, 32'h14,  1, 32'hC);
    vecs[12] = mk(1, 1, 32'h203, 0, 0, 1, 32'h10);
    vecs[13] = mk(1, 0, 0, 1, 32'h200, 0, 0);
    vecs[14] = mk(1, 0, 0, 1, 32'h204, 0, 0);
    vecs[15] = mk(1, 0, 0, 1, 32'h208, 1, 32'h200);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_pc4", inst_pc4, 32'h4);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_after_release", imem_req_valid, 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      inst_ready      = vecs[i].ir;
      redirect        = vecs[i].rd;
      redirect_target = vecs[i].tgt;
      #1;
      chk($sformatf("v%0d_req_valid", i), imem_req_valid, vecs[i].erv);
      if (vecs[i].erv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].eaddr);
      chk($sformatf("v%0d_inst_valid", i), inst_valid, vecs[i].eiv);
      if (vecs[i].eiv) begin
        chk($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].epc);
        chk($sformatf("v%0d_inst_pc4", i), inst_pc4, vecs[i].epc + 32'd4);
        chk($sformatf("v%0d_inst_data", i), inst_data, vecs[i].epc ^ KEY);
      end
    end

    // Memory not ready for 4 cycles at pc 0x20.
    @(negedge clk);
    redirect = 1'b1; redirect_target = 32'h20; inst_ready = 1'b1;
    #1;
    chk("a_redir_req_valid", imem_req_valid, 0);
    @(negedge clk);
    redirect = 1'b0; imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("a_stall_valid", imem_req_valid, 1);
      chk("a_stall_addr", imem_req_addr, 32'h20);
      chk("a_stall_inst_valid", inst_valid, 0);
      @(negedge clk);
    end
    imem_req_ready = 1'b1;
    #1;
    chk("a_release_addr", imem_req_addr, 32'h20);
    @(negedge clk); #1;
    chk("a_next_addr", imem_req_addr, 32'h24);
    @(negedge clk); #1;
    chk("a_inst_valid", inst_valid, 1);
    chk("a_inst_pc", inst_pc, 32'h20);
    chk("a_inst_data", inst_data, 32'h20 ^ KEY);

    // Redirect to 0x100 with a 3-cycle request outstanding.
    mem_lat = 3;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk); #1;
      if (imem_req_valid && imem_req_ready) ok = 1'b1;
    end
    chk("b_accept_seen", ok, 1);
    @(negedge clk);
    redirect = 1'b1; redirect_target = 32'h100;
    #1;
    chk("b_redir_req_valid", imem_req_valid, 0);
    @(negedge clk);
    redirect = 1'b0;
    ok = 1'b0; seen = 1'b0;
    for (int i = 0; i < 15 && !ok; i++) begin
      #1;
      if (imem_req_valid && !seen) begin
        chk("b_first_addr", imem_req_addr, 32'h100);
        seen = 1'b1;
      end
      if (inst_valid) ok = 1'b1;
      else @(negedge clk);
    end
    chk("b_inst_seen", ok, 1);
    chk("b_inst_pc", inst_pc, 32'h100);
    chk("b_inst_data", inst_data, 32'h100 ^ KEY);

    // Redirect to the top of the address space; pc wraps to 0.
    mem_lat = 1;
    @(negedge clk);
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (imem_req_valid) ok = 1'b1;
      else @(negedge clk);
    end
    chk("c_req_seen", ok, 1);
    chk("c_first_addr", imem_req_addr, 32'hFFFF_FFFC);
    wait_inst(ok);
    chk("c_inst_seen", ok, 1);
    chk("c_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("c_inst_pc4", inst_pc4, 32'h0);
    chk("c_inst_data", inst_data, 32'hFFFF_FFFC ^ KEY);
    @(negedge clk);
    wait_inst(ok);
    chk("c_wrap_seen", ok, 1);
    chk("c_wrap_pc", inst_pc, 32'h0);
    chk("c_wrap_pc4", inst_pc4, 32'h4);

    // Asynchronous reset with a buffered entry and a request outstanding.
    @(negedge clk);
    inst_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h300; mem_lat = 3;
    @(negedge clk);
    redirect = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h304) ok = 1'b1;
      else @(negedge clk);
    end
    chk("d_second_accept", ok, 1);
    @(negedge clk); #1;
    chk("d_pre_inst_valid", inst_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("d_rst_req_valid", imem_req_valid, 0);
    chk("d_rst_inst_valid", inst_valid, 0);
    chk("d_rst_inst_data", inst_data, 0);
    chk("d_rst_inst_pc", inst_pc, 0);
    chk("d_rst_inst_pc4", inst_pc4, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("d_idle_after_release", imem_req_valid, 0);
    inst_ready = 1'b1;
    @(negedge clk);
    wait_inst(ok);
    chk("d_inst_seen", ok, 1);
    chk("d_inst_pc", inst_pc, 32'h0);
    chk("d_inst_data", inst_data, 32'h0 ^ KEY);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
